// File: rtl/synth_audio_pkg.sv
// Shared audio definitions for the synth engine: default sample width,
// channel count and the stereo sample pair type. Define _24BitAudio for 24-bit builds.
package synth_audio_pkg;

`ifdef _24BitAudio
  localparam int DEFAULT_DATA_WIDTH = 24;
`else
  localparam int DEFAULT_DATA_WIDTH = 16;
`endif

  localparam int CHANNEL_NUM = 2;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] left;
    logic [DEFAULT_DATA_WIDTH-1:0] right;
  } stereo_pair_t;

endpackage

// File: rtl/audio_edge_det.sv
// Rising/falling edge detector for a strobe already in the clk domain.
// The history register only advances when en_i is high.
module audio_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic strobe_i,
  output logic rise_o,
  output logic fall_o
);

  logic strobe_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
    end else if (en_i) begin
      strobe_q <= strobe_i;
    end
  end

  assign rise_o = en_i &  strobe_i & ~strobe_q;
  assign fall_o = en_i & ~strobe_i &  strobe_q;

endmodule

// File: rtl/i2s_dac_serializer.sv
// I2S serializer for the codec DAC: one-deep stereo buffer, MSB-first shift with one-BCK delay.
// Define UNDERRUN_HOLD_EN to repeat the last pair on underrun instead of playing silence.
module i2s_dac_serializer
  import synth_audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  AUDIO_CLK,
  input  logic                  reset_reg_N,
  input  logic                  LRCK_1X,
  input  logic                  iAUD_BCK,
  input  logic [DATA_WIDTH-1:0] lsound_in,
  input  logic [DATA_WIDTH-1:0] rsound_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  sample_req,
  output logic                  underrun,
  output logic                  oAUD_DACDAT
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } pair_t;

  logic bck_fall, bck_rise_unused;
  logic lrck_rise, lrck_fall;
  logic slot_start, frame_start, accept;

  logic [DATA_WIDTH:0] sreg_q, sreg_d, shift_src;
  logic                dacdat_q, dacdat_d;
  pair_t               act_q, act_d, buf_q, buf_d;
  logic                buf_full_q, buf_full_d;
  logic                sample_req_q, sample_req_d;
  logic                underrun_q, underrun_d;

  audio_edge_det u_bck_edge (
    .clk      (AUDIO_CLK),
    .rst_n    (reset_reg_N),
    .en_i     (1'b1),
    .strobe_i (iAUD_BCK),
    .rise_o   (bck_rise_unused),
    .fall_o   (bck_fall)
  );

  // LRCK history only advances on BCK falls, so slot starts align to bit boundaries.
  audio_edge_det u_lrck_edge (
    .clk      (AUDIO_CLK),
    .rst_n    (reset_reg_N),
    .en_i     (bck_fall),
    .strobe_i (LRCK_1X),
    .rise_o   (lrck_rise),
    .fall_o   (lrck_fall)
  );

  assign slot_start  = lrck_rise | lrck_fall;
  assign frame_start = lrck_fall;
  assign accept      = in_valid & ~buf_full_q;

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    sreg_d       = sreg_q;
    dacdat_d     = dacdat_q;
    act_d        = act_q;
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    sample_req_d = 1'b0;
    underrun_d   = 1'b0;
    shift_src    = sreg_q;

    if (accept) begin
      buf_d.left  = lsound_in;
      buf_d.right = rsound_in;
      buf_full_d  = 1'b1;
    end

    if (frame_start) begin
      sample_req_d = 1'b1;
      if (buf_full_q) begin
        act_d      = buf_q;
        buf_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
`ifdef UNDERRUN_HOLD_EN
        act_d = act_q;
`else
        act_d = '0;
`endif
      end
    end

    // act_d bypasses the transfer so the left slot plays the pair just taken from the buffer.
    if (bck_fall) begin
      if (slot_start) begin
        shift_src = {1'b0, (LRCK_1X ? act_d.right : act_d.left)};
      end
      dacdat_d = shift_src[DATA_WIDTH];
      sreg_d   = {shift_src[DATA_WIDTH-1:0], 1'b0};
    end
  end

  // NOTE: sample storage is reset too, so no stale audio reaches the DAC after a reset.
  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      sreg_q       <= '0;
      dacdat_q     <= 1'b0;
      act_q        <= '0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      sample_req_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      sreg_q       <= sreg_d;
      dacdat_q     <= dacdat_d;
      act_q        <= act_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      sample_req_q <= sample_req_d;
      underrun_q   <= underrun_d;
    end
  end

  assign in_ready    = ~buf_full_q;
  assign sample_req  = sample_req_q;
  assign underrun    = underrun_q;
  assign oAUD_DACDAT = dacdat_q;

endmodule
